roi_scan_io: RTL and testbench

Serial scan front/back end for the BRAM region-of-interest harness. It shifts a DIN_N-bit stimulus word in from one serial pin and applies it in parallel to the ROI inputs. After a programmable settle time it captures the ROI's DOUT_N-bit output and shifts it back out on one serial pin with a valid/ready handshake. It replaces a free-running shift pair plus external strobe with a self-sequencing FSM, so one serial frame in yields exactly one serial frame out.

---
 rtl/roi_scan_pkg.sv | 18 +
 rtl/roi_scan_io_if.sv | 25 ++
 rtl/scan_shreg.sv | 31 +++
 rtl/roi_scan_io.sv | 161 ++++++++++++++++
 tb/tb_roi_scan_io.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/roi_scan_pkg.sv
// roi_scan_pkg: shared types and helpers for the ROI serial scan block.
//   state_e : sequencing states of the scan FSM
//   cnt_w   : bit width needed to hold the values 0..n
package roi_scan_pkg;

  typedef enum logic [2:0] {
    LOAD,
    APPLY,
    SETTLE,
    CAPTURE,
    UNLOAD
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/roi_scan_io_if.sv
// roi_scan_io_if: serial stimulus-in and result-out handshake pair.
//   di/di_valid/di_ready : serial stimulus stream into the scan block
//   so/so_valid/so_ready : serial result stream out of the scan block
//   master : host side (sends di, consumes so)
//   slave  : scan block side
interface roi_scan_io_if;

  logic di;
  logic di_valid;
  logic di_ready;
  logic so;
  logic so_valid;
  logic so_ready;

  modport master (
    output di, di_valid, so_ready,
    input  di_ready, so, so_valid
  );

  modport slave (
    input  di, di_valid, so_ready,
    output di_ready, so, so_valid
  );

endinterface

// File: rtl/scan_shreg.sv
// scan_shreg: WIDTH-bit left-shift register with parallel load and MSB tap.
//   shift_en  : shift left by one, shift_in enters at bit 0
//   load_en   : parallel load of load_data (wins over shift_en)
//   q         : register contents
//   msb       : q[WIDTH-1]
module scan_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             msb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], shift_in};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/roi_scan_io.sv
// roi_scan_io: serial scan front/back end for the BRAM ROI harness.
// Shifts a DIN_N-bit word in MSB-first, applies it to the ROI, waits
// SETTLE_CYC cycles, captures the DOUT_N-bit result and shifts it out
// MSB-first. One serial frame in yields exactly one serial frame out.
//   clk, rst_n  : clock, asynchronous active-low reset
//   sio         : serial in/out handshake (slave side)
//   din         : registered parallel stimulus to the ROI
//   dout        : parallel result from the ROI
//   busy        : frame in flight (any state other than LOAD)
//   frame_done  : pulse in the cycle of the final result-bit accept
//   frame_cnt   : completed frames, wrapping
module roi_scan_io
  import roi_scan_pkg::*;
#(
  parameter int unsigned DIN_N      = 256,
  parameter int unsigned DOUT_N     = 256,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  roi_scan_io_if.slave      sio,
  output logic [DIN_N-1:0]  din,
  input  logic [DOUT_N-1:0] dout,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned MAX_N  = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int unsigned CNT_W  = cnt_w(MAX_N);
  localparam int unsigned WAIT_W = cnt_w(SETTLE_CYC);

  if (DIN_N < 2) begin : g_bad_din_n
    $error("roi_scan_io: DIN_N must be >= 2");
  end
  if (DOUT_N < 2) begin : g_bad_dout_n
    $error("roi_scan_io: DOUT_N must be >= 2");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("roi_scan_io: SETTLE_CYC must be >= 1");
  end

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [FCNT_W-1:0]   frame_cnt_nxt;
  logic [DIN_N-1:0]    din_nxt;
  logic [DIN_N-1:0]    din_shr_q;
  logic                din_shift;
  logic                dout_load;
  logic                dout_shift;
  logic                so_bit;
  logic                unused_din_msb;
  logic [DOUT_N-1:0]   unused_dout_q;

  // Handshake qualifiers and status decode from the state register only
  assign sio.di_ready = (state == LOAD);
  assign sio.so_valid = (state == UNLOAD);
  assign busy         = (state != LOAD);
  assign sio.so       = so_bit;

  // Stimulus shift register: first accepted bit ends up in the MSB
  scan_shreg #(.WIDTH(DIN_N)) din_shr (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (din_shift),
    .load_en   (1'b0),
    .shift_in  (sio.di),
    .load_data ('0),
    .q         (din_shr_q),
    .msb       (unused_din_msb)
  );

  // Result shift register: loads the ROI output, drains MSB-first
  scan_shreg #(.WIDTH(DOUT_N)) dout_shr (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (dout_shift),
    .load_en   (dout_load),
    .shift_in  (1'b0),
    .load_data (dout),
    .q         (unused_dout_q),
    .msb       (so_bit)
  );

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      frame_cnt <= '0;
      din       <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      din       <= din_nxt;
    end
  end

  // Frame sequencing; bit_cnt is shared by the load and unload phases
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    wait_cnt_nxt  = wait_cnt;
    frame_cnt_nxt = frame_cnt;
    din_nxt       = din;
    din_shift     = 1'b0;
    dout_load     = 1'b0;
    dout_shift    = 1'b0;
    frame_done    = 1'b0;

    unique case (state)
      LOAD: begin
        if (sio.di_valid) begin
          din_shift = 1'b1;
          if (bit_cnt == CNT_W'(DIN_N - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = APPLY;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      APPLY: begin
        din_nxt   = din_shr_q;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (wait_cnt == WAIT_W'(SETTLE_CYC - 1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = CAPTURE;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      CAPTURE: begin
        dout_load = 1'b1;
        state_nxt = UNLOAD;
      end
      UNLOAD: begin
        if (sio.so_ready) begin
          dout_shift = 1'b1;
          if (bit_cnt == CNT_W'(DOUT_N - 1)) begin
            frame_done    = 1'b1;
            frame_cnt_nxt = frame_cnt + FCNT_W'(1);
            bit_cnt_nxt   = '0;
            state_nxt     = LOAD;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

endmodule

// File: tb/tb_roi_scan_io.sv
// tb_roi_scan_io: self-checking bench for roi_scan_io.
// DUT a: DIN_N=DOUT_N=8, SETTLE_CYC=2, FCNT_W=2 (directed + random frames).
// DUT b: DIN_N=4, DOUT_N=12, SETTLE_CYC=1 (mismatched widths).
// ROI model: dout is din XOR a per-frame key (replicated for DUT b).
module tb_roi_scan_io;

  localparam int unsigned S_A = 2;
  localparam int unsigned S_B = 1;

  logic        clk;
  logic        rst_n;

  roi_scan_io_if sa ();
  roi_scan_io_if sb ();

  logic [7:0]  din_a, dout_a, key_a;
  logic        busy_a, fd_a;
  logic [1:0]  fcnt_a;

  logic [3:0]  din_b;
  logic [11:0] dout_b, key_b;
  logic        busy_b, fd_b;
  logic [15:0] fcnt_b;

  int ncmp;
  int nfail;
  logic [7:0] din_prev_a;
  logic [3:0] din_prev_b;
  int fcnt_model_a;
  int fcnt_model_b;

  assign dout_a = din_a ^ key_a;
  assign dout_b = {din_b, din_b, din_b} ^ key_b;

  roi_scan_io #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(S_A), .FCNT_W(2)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sio        (sa),
    .din        (din_a),
    .dout       (dout_a),
    .busy       (busy_a),
    .frame_done (fd_a),
    .frame_cnt  (fcnt_a)
  );

  roi_scan_io #(.DIN_N(4), .DOUT_N(12), .SETTLE_CYC(S_B), .FCNT_W(16)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sio        (sb),
    .din        (din_b),
    .dout       (dout_b),
    .busy       (busy_b),
    .frame_done (fd_b),
    .frame_cnt  (fcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame through DUT a. gaps: idle cycle before every di bit.
  // stall_at: result beat at which so_ready drops for 10 cycles (-1 none).
  // abort_at: result beat at which reset is asserted (-1 none).
  task automatic frame_a(input logic [7:0] word, input logic [7:0] key,
                         input bit gaps, input int stall_at, input int abort_at);
    logic [7:0] exp_so;
    key_a  = key;
    exp_so = word ^ key;
    for (int i = 7; i >= 0; i--) begin
      if (gaps) begin
        sa.di = 1'($urandom);
        sa.di_valid = 1'b0;
        @(negedge clk);
      end
      chk("a_load_di_ready", sa.di_ready, 1);
      chk("a_load_busy", busy_a, 0);
      sa.di = word[i];
      sa.di_valid = 1'b1;
      @(negedge clk);
    end
    // Cycle after last accept: APPLY, din not yet updated
    sa.di_valid = 1'($urandom);
    sa.di = 1'($urandom);
    chk("a_apply_busy", busy_a, 1);
    chk("a_apply_di_ready", sa.di_ready, 0);
    chk("a_din_hold", din_a, din_prev_a);
    for (int k = 0; k <= int'(S_A); k++) begin
      @(negedge clk);
      sa.di_valid = 1'($urandom);
      sa.di = 1'($urandom);
      chk("a_din_new", din_a, word);
      chk("a_so_valid_early", sa.so_valid, 0);
    end
    @(negedge clk);
    din_prev_a = word;
    for (int b = 0; b < 8; b++) begin
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("a_abort_din", din_a, 0);
        chk("a_abort_so_valid", sa.so_valid, 0);
        chk("a_abort_di_ready", sa.di_ready, 1);
        chk("a_abort_frame_done", fd_a, 0);
        chk("a_abort_frame_cnt", fcnt_a, 0);
        fcnt_model_a = 0;
        fcnt_model_b = 0;
        din_prev_a = '0;
        din_prev_b = '0;
        sa.di_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      sa.di_valid = 1'($urandom);
      sa.di = 1'($urandom);
      if (b == stall_at) begin
        sa.so_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          chk("a_stall_so_valid", sa.so_valid, 1);
          chk("a_stall_so", sa.so, exp_so[7-b]);
          chk("a_stall_frame_done", fd_a, 0);
        end
        sa.so_ready = 1'b1;
        #1;
      end
      chk("a_so_valid", sa.so_valid, 1);
      chk("a_so", sa.so, exp_so[7-b]);
      chk("a_frame_done", fd_a, (b == 7));
      @(negedge clk);
    end
    sa.di_valid = 1'b0;
    fcnt_model_a = (fcnt_model_a + 1) % 4;
    chk("a_end_so_valid", sa.so_valid, 0);
    chk("a_end_di_ready", sa.di_ready, 1);
    chk("a_end_busy", busy_a, 0);
    chk("a_end_frame_done", fd_a, 0);
    chk("a_frame_cnt", fcnt_a, fcnt_model_a);
    chk("a_end_din", din_a, word);
  endtask

  // One frame through DUT b with random input gaps, so_ready held high
  task automatic frame_b(input logic [3:0] word, input logic [11:0] key);
    logic [11:0] exp_so;
    key_b  = key;
    exp_so = {word, word, word} ^ key;
    for (int i = 3; i >= 0; i--) begin
      if ($urandom_range(0, 1) == 1) begin
        sb.di_valid = 1'b0;
        @(negedge clk);
      end
      chk("b_load_di_ready", sb.di_ready, 1);
      sb.di = word[i];
      sb.di_valid = 1'b1;
      @(negedge clk);
    end
    sb.di_valid = 1'($urandom);
    chk("b_apply_di_ready", sb.di_ready, 0);
    chk("b_din_hold", din_b, din_prev_b);
    for (int k = 0; k <= int'(S_B); k++) begin
      @(negedge clk);
      chk("b_din_new", din_b, word);
      chk("b_so_valid_early", sb.so_valid, 0);
    end
    @(negedge clk);
    din_prev_b = word;
    for (int b = 0; b < 12; b++) begin
      sb.di_valid = 1'($urandom);
      chk("b_so_valid", sb.so_valid, 1);
      chk("b_so", sb.so, exp_so[11-b]);
      chk("b_frame_done", fd_b, (b == 11));
      @(negedge clk);
    end
    sb.di_valid = 1'b0;
    fcnt_model_b = fcnt_model_b + 1;
    chk("b_end_so_valid", sb.so_valid, 0);
    chk("b_end_di_ready", sb.di_ready, 1);
    chk("b_frame_cnt", fcnt_b, fcnt_model_b);
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    din_prev_a = '0;
    din_prev_b = '0;
    fcnt_model_a = 0;
    fcnt_model_b = 0;
    key_a = '0;
    key_b = '0;
    sa.di = 1'b0; sa.di_valid = 1'b0; sa.so_ready = 1'b1;
    sb.di = 1'b0; sb.di_valid = 1'b0; sb.so_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_di_ready", sa.di_ready, 1);
    chk("rst_so", sa.so, 0);
    chk("rst_so_valid", sa.so_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_frame_cnt", fcnt_a, 0);
    chk("rst_din", din_a, 0);
    chk("rst_b_din", din_b, 0);
    chk("rst_b_so_valid", sb.so_valid, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: no stimulus must not leave LOAD
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_di_ready", sa.di_ready, 1);
      chk("idle_busy", busy_a, 0);
    end
    chk("idle_so_valid", sa.so_valid, 0);
    chk("idle_frame_cnt", fcnt_a, 0);

    // A5 in, ROI returns 3C
    frame_a(8'hA5, 8'h99, 1'b0, -1, -1);
    // Gapped input, stall mid-unload
    frame_a(8'hA5, 8'h99, 1'b1, 3, -1);
    // Reset at result beat 4
    frame_a(8'($urandom), 8'($urandom), 1'b0, -1, 4);
    frame_a(8'hFF, 8'($urandom), 1'b0, -1, -1);
    // Random frames; frame_cnt wraps through 2,3,0,1
    for (int f = 0; f < 4; f++) begin
      frame_a(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 8)) - 1, -1);
    end

    for (int f = 0; f < 5; f++) begin
      frame_b(4'($urandom), 12'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
